// File: rtl/synth_pkg.sv
// Shared types for the synth front end: MIDI status nibbles, waveform codes,
// decoded event record and parser state encoding.
package synth_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] BEND     = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    WAVE_SAW      = 3'b000,
    WAVE_SQUARE   = 3'b001,
    WAVE_TRIANGLE = 3'b010,
    WAVE_SINE     = 3'b011,
    WAVE_PULSE    = 3'b100,
    WAVE_SUPERSAW = 3'b101,
    WAVE_SYNC     = 3'b110,
    WAVE_NOISE    = 3'b111
  } wave_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_ON,
    EV_OFF,
    EV_CC,
    EV_BEND
  } ev_type_e;

  typedef struct packed {
    ev_type_e   ev_type;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_event_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_WAIT_D1,
    P_WAIT_D2
  } parse_state_e;

  function automatic logic is_voice_status(input logic [3:0] nib);
    return (nib == NOTE_OFF) || (nib == NOTE_ON) || (nib == CC) || (nib == BEND);
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte stream to decoded channel-voice events with running status.
// The event strobe is combinational on the cycle the second data byte arrives.
module midi_msg_parser
  import synth_pkg::*;
#(
  parameter int unsigned MIDI_CH = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  output logic        ev_valid_o,
  output midi_event_t ev_o
);

  parse_state_e state_q;
  logic         rs_valid_q;
  logic [3:0]   rs_type_q;
  logic [6:0]   d1_q;

  always_comb begin
    ev_valid_o = rx_valid_i && !rx_byte_i[7] && (state_q == P_WAIT_D2);
    ev_o.d1    = d1_q;
    ev_o.d2    = rx_byte_i[6:0];
    case (rs_type_q)
      NOTE_OFF: ev_o.ev_type = EV_OFF;
      NOTE_ON:  ev_o.ev_type = (rx_byte_i[6:0] == 7'd0) ? EV_OFF : EV_ON;
      CC:       ev_o.ev_type = EV_CC;
      BEND:     ev_o.ev_type = EV_BEND;
      default:  ev_o.ev_type = EV_NONE;
    endcase
  end

  // Real-time bytes (F8..FF) fall through every branch and leave state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= P_IDLE;
      rs_valid_q <= 1'b0;
      rs_type_q  <= 4'h0;
      d1_q       <= 7'd0;
    end else if (rx_valid_i && (rx_byte_i < 8'hF8)) begin
      if (rx_byte_i >= 8'hF0) begin
        state_q    <= P_IDLE;
        rs_valid_q <= 1'b0;
      end else if (rx_byte_i[7]) begin
        rs_type_q <= rx_byte_i[7:4];
        if ((rx_byte_i[3:0] == 4'(MIDI_CH)) && is_voice_status(rx_byte_i[7:4])) begin
          rs_valid_q <= 1'b1;
          state_q    <= P_WAIT_D1;
        end else begin
          rs_valid_q <= 1'b0;
          state_q    <= P_IDLE;
        end
      end else begin
        case (state_q)
          P_IDLE: begin
            if (rs_valid_q) begin
              d1_q    <= rx_byte_i[6:0];
              state_q <= P_WAIT_D2;
            end
          end
          P_WAIT_D1: begin
            d1_q    <= rx_byte_i[6:0];
            state_q <= P_WAIT_D2;
          end
          P_WAIT_D2: state_q <= P_WAIT_D1;
          default:   state_q <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_voice_assigner.sv
// Polyphonic front end: decodes MIDI, allocates/steals voices, runs gate
// retrigger timers and holds the shared pitch/detune/mix/waveform controls.
module midi_voice_assigner
  import synth_pkg::*;
#(
  parameter int unsigned VOICES     = 4,
  parameter int unsigned MIDI_CH    = 0,
  parameter int unsigned CC_DETUNE  = 94,
  parameter int unsigned CC_MIX     = 95,
  parameter int unsigned CC_WAVE    = 70,
  parameter int unsigned RETRIG_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [VOICES-1:0]     gate,
  output logic [7*VOICES-1:0]   note,
  output logic [13:0]           pitch,
  output logic [6:0]            detune,
  output logic [6:0]            mix,
  output logic [2:0]            wave_form,
  output logic                  overflow
);

  localparam int CW = $clog2(RETRIG_CYC + 1);
  localparam int PW = $clog2(VOICES);

  logic        ev_valid;
  midi_event_t ev;

  midi_msg_parser #(.MIDI_CH(MIDI_CH)) u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .ev_valid_o (ev_valid),
    .ev_o       (ev)
  );

  logic [VOICES-1:0] gate_q, gate_d;
  logic [6:0]        note_q [VOICES];
  logic [6:0]        note_d [VOICES];
  logic [CW-1:0]     cnt_q  [VOICES];
  logic [CW-1:0]     cnt_d  [VOICES];
  logic [PW-1:0]     steal_q, steal_d;
  logic [13:0]       pitch_q, pitch_d;
  logic [6:0]        detune_q, detune_d;
  logic [6:0]        mix_q, mix_d;
  wave_e             wave_q, wave_d;
  logic              overflow_q, overflow_d;

  logic              hit_any, free_any;
  logic [PW-1:0]     hit_idx, free_idx;

  // A voice still inside its retrigger window counts as holding its note,
  // so a repeated note-on restarts that voice instead of grabbing another.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if ((note_q[v] == ev.d1) && (gate_q[v] || (cnt_q[v] != '0))) begin
        hit_any = 1'b1;
        hit_idx = PW'(v);
      end
      if (!gate_q[v] && (cnt_q[v] == '0)) begin
        free_any = 1'b1;
        free_idx = PW'(v);
      end
    end
  end

  always_comb begin
    gate_d     = gate_q;
    note_d     = note_q;
    cnt_d      = cnt_q;
    steal_d    = steal_q;
    pitch_d    = pitch_q;
    detune_d   = detune_q;
    mix_d      = mix_q;
    wave_d     = wave_q;
    overflow_d = 1'b0;

    for (int v = 0; v < VOICES; v++) begin
      if (cnt_q[v] != '0) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
        if (cnt_q[v] == CW'(1)) gate_d[v] = 1'b1;
      end
    end

    // Events override the timer update above for any voice they touch.
    if (ev_valid) begin
      case (ev.ev_type)
        EV_ON: begin
          if (hit_any) begin
            gate_d[hit_idx] = 1'b0;
            cnt_d[hit_idx]  = CW'(RETRIG_CYC);
          end else if (free_any) begin
            note_d[free_idx] = ev.d1;
            gate_d[free_idx] = 1'b1;
            cnt_d[free_idx]  = '0;
          end else begin
            note_d[steal_q] = ev.d1;
            gate_d[steal_q] = 1'b0;
            cnt_d[steal_q]  = CW'(RETRIG_CYC);
            overflow_d      = 1'b1;
            steal_d         = (steal_q == PW'(VOICES - 1)) ? '0 : steal_q + PW'(1);
          end
        end
        EV_OFF: begin
          for (int v = 0; v < VOICES; v++) begin
            if ((note_q[v] == ev.d1) && (gate_q[v] || (cnt_q[v] != '0))) begin
              gate_d[v] = 1'b0;
              cnt_d[v]  = '0;
            end
          end
        end
        EV_CC: begin
          if (ev.d1 == 7'(CC_DETUNE)) detune_d = ev.d2;
          else if (ev.d1 == 7'(CC_MIX)) mix_d = ev.d2;
          else if (ev.d1 == 7'(CC_WAVE)) wave_d = wave_e'(ev.d2[6:4]);
          else if (ev.d1 == CC_ALL_NOTES_OFF) begin
            gate_d = '0;
            for (int v = 0; v < VOICES; v++) cnt_d[v] = '0;
          end
        end
        EV_BEND: pitch_d = {ev.d2, ev.d1};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q     <= '0;
      for (int v = 0; v < VOICES; v++) begin
        note_q[v] <= 7'd0;
        cnt_q[v]  <= '0;
      end
      steal_q    <= '0;
      pitch_q    <= 14'h2000;
      detune_q   <= 7'd0;
      mix_q      <= 7'd0;
      wave_q     <= WAVE_SAW;
      overflow_q <= 1'b0;
    end else begin
      gate_q     <= gate_d;
      note_q     <= note_d;
      cnt_q      <= cnt_d;
      steal_q    <= steal_d;
      pitch_q    <= pitch_d;
      detune_q   <= detune_d;
      mix_q      <= mix_d;
      wave_q     <= wave_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    for (int v = 0; v < VOICES; v++) note[7*v +: 7] = note_q[v];
  end

  assign gate      = gate_q;
  assign pitch     = pitch_q;
  assign detune    = detune_q;
  assign mix       = mix_q;
  assign wave_form = wave_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_midi_voice_assigner.sv
// Directed bench for midi_voice_assigner: cumulative vector table followed by
// hand-written steal, retrigger, interleave and async-reset sequences.
module tb_midi_voice_assigner;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [3:0]  gate;
  logic [27:0] note;
  logic [13:0] pitch;
  logic [6:0]  detune;
  logic [6:0]  mix;
  logic [2:0]  wave_form;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];

  midi_voice_assigner #(
    .VOICES(4), .MIDI_CH(0), .CC_DETUNE(94), .CC_MIX(95), .CC_WAVE(70), .RETRIG_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .gate      (gate),
    .note      (note),
    .pitch     (pitch),
    .detune    (detune),
    .mix       (mix),
    .wave_form (wave_form),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nb;
    logic [7:0]  b0, b1, b2;
    logic [3:0]  gate;
    logic [27:0] note;
    logic [13:0] pitch;
    logic [6:0]  det;
    logic [6:0]  mix;
    logic [2:0]  wave;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [3:0] g, input logic [27:0] n,
                              input logic [13:0] p, input logic [6:0] d, input logic [6:0] m,
                              input logic [2:0] w);
    vec_t r;
    r.nb = nb; r.b0 = b0; r.b1 = b1; r.b2 = b2;
    r.gate = g; r.note = n; r.pitch = p; r.det = d; r.mix = m; r.wave = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver: one byte per clock, returns at posedge+1 with outputs settled
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // scoreboard: pop one expected gate word per cycle
  task automatic drain_gate(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      if (n > 0) step();
      check(name, gate, exp_q.pop_front());
      n++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gate", gate, 4'b0000);
    check("rst_note", note, 28'h0);
    check("rst_pitch", pitch, 14'h2000);
    check("rst_detune", detune, 7'h00);
    check("rst_mix", mix, 7'h00);
    check("rst_wave", wave_form, 3'b000);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    step();

    vecs[0]  = mk(3, 8'h90, 8'h3C, 8'h64, 4'b0001, 28'h000003C, 14'h2000, 7'h00, 7'h00, 3'd0);
    vecs[1]  = mk(2, 8'h3E, 8'h64, 8'h00, 4'b0011, 28'h0001F3C, 14'h2000, 7'h00, 7'h00, 3'd0);
    vecs[2]  = mk(3, 8'hE0, 8'h00, 8'h40, 4'b0011, 28'h0001F3C, 14'h2000, 7'h00, 7'h00, 3'd0);
    vecs[3]  = mk(3, 8'hE0, 8'h7F, 8'h7F, 4'b0011, 28'h0001F3C, 14'h3FFF, 7'h00, 7'h00, 3'd0);
    vecs[4]  = mk(3, 8'hB0, 8'h5E, 8'h55, 4'b0011, 28'h0001F3C, 14'h3FFF, 7'h55, 7'h00, 3'd0);
    vecs[5]  = mk(3, 8'hB0, 8'h5F, 8'h2A, 4'b0011, 28'h0001F3C, 14'h3FFF, 7'h55, 7'h2A, 3'd0);
    vecs[6]  = mk(3, 8'hB0, 8'h46, 8'h30, 4'b0011, 28'h0001F3C, 14'h3FFF, 7'h55, 7'h2A, 3'd3);
    vecs[7]  = mk(3, 8'hB0, 8'h10, 8'h7F, 4'b0011, 28'h0001F3C, 14'h3FFF, 7'h55, 7'h2A, 3'd3);
    vecs[8]  = mk(3, 8'h80, 8'h3C, 8'h40, 4'b0010, 28'h0001F3C, 14'h3FFF, 7'h55, 7'h2A, 3'd3);
    vecs[9]  = mk(3, 8'h90, 8'h3E, 8'h00, 4'b0000, 28'h0001F3C, 14'h3FFF, 7'h55, 7'h2A, 3'd3);
    vecs[10] = mk(3, 8'h90, 8'h41, 8'h64, 4'b0001, 28'h0001F41, 14'h3FFF, 7'h55, 7'h2A, 3'd3);
    vecs[11] = mk(3, 8'h91, 8'h3C, 8'h64, 4'b0001, 28'h0001F41, 14'h3FFF, 7'h55, 7'h2A, 3'd3);
    vecs[12] = mk(2, 8'h3C, 8'h64, 8'h00, 4'b0001, 28'h0001F41, 14'h3FFF, 7'h55, 7'h2A, 3'd3);
    vecs[13] = mk(3, 8'hB0, 8'h7B, 8'h00, 4'b0000, 28'h0001F41, 14'h3FFF, 7'h55, 7'h2A, 3'd3);

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < vecs[i].nb; k++)
        send(k == 0 ? vecs[i].b0 : (k == 1 ? vecs[i].b1 : vecs[i].b2));
      check($sformatf("v%0d_gate", i), gate, vecs[i].gate);
      check($sformatf("v%0d_note", i), note, vecs[i].note);
      check($sformatf("v%0d_pitch", i), pitch, vecs[i].pitch);
      check($sformatf("v%0d_detune", i), detune, vecs[i].det);
      check($sformatf("v%0d_mix", i), mix, vecs[i].mix);
      check($sformatf("v%0d_wave", i), wave_form, vecs[i].wave);
    end

    // voice stealing, back-to-back bytes with running status
    do_reset();
    send(8'h90); send(8'h40); send(8'h64);
    send(8'h41); send(8'h64); send(8'h42); send(8'h64); send(8'h43); send(8'h64);
    check("fill_gate", gate, 4'b1111);
    check("fill_note", note, {7'h43, 7'h42, 7'h41, 7'h40});
    check("fill_overflow", overflow, 1'b0);
    send(8'h44); send(8'h64);
    check("steal0_overflow", overflow, 1'b1);
    check("steal0_note", note, {7'h43, 7'h42, 7'h41, 7'h44});
    exp_q.push_back(4'b1110); exp_q.push_back(4'b1110); exp_q.push_back(4'b1111);
    drain_gate("steal0_gate");
    step();
    check("steal0_overflow_end", overflow, 1'b0);
    send(8'h45); send(8'h64);
    check("steal1_overflow", overflow, 1'b1);
    check("steal1_note", note, {7'h43, 7'h42, 7'h45, 7'h44});
    exp_q.push_back(4'b1101); exp_q.push_back(4'b1101); exp_q.push_back(4'b1111);
    drain_gate("steal1_gate");

    // retrigger of a held note
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    check("retrig_on", gate, 4'b0001);
    send(8'h90); send(8'h3C); send(8'h70);
    check("retrig_overflow", overflow, 1'b0);
    exp_q.push_back(4'b0000); exp_q.push_back(4'b0000); exp_q.push_back(4'b0001);
    drain_gate("retrig_gate");
    check("retrig_note", note, 28'h000003C);

    // note on during retrigger restarts the timer on the same voice
    send(8'h3C); send(8'h70);
    send(8'h3C); send(8'h70);
    exp_q.push_back(4'b0000); exp_q.push_back(4'b0000); exp_q.push_back(4'b0001);
    drain_gate("restart_gate");
    check("restart_note", note, 28'h000003C);

    // note off during retrigger keeps gate low
    send(8'h3C); send(8'h70);
    send(8'h3C); send(8'h00);
    exp_q.push_back(4'b0000); exp_q.push_back(4'b0000); exp_q.push_back(4'b0000);
    drain_gate("off_in_retrig_gate");

    // note off by velocity 0 keeps note; unmatched note off is a no-op
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h90); send(8'h3C); send(8'h00);
    check("vel0_gate", gate, 4'b0000);
    check("vel0_note", note, 28'h000003C);
    send(8'h80); send(8'h3C); send(8'h40);
    check("nomatch_gate", gate, 4'b0000);
    check("nomatch_note", note, 28'h000003C);

    // real-time byte interleaved, sysex cancel, status abort
    do_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    check("rt_gate", gate, 4'b0001);
    check("rt_note", note, 28'h000003C);
    do_reset();
    send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
    check("sysex_gate", gate, 4'b0000);
    send(8'h90); send(8'h3C); send(8'h90); send(8'h3D); send(8'h64);
    check("abort_gate", gate, 4'b0001);
    check("abort_note", note, 28'h000003D);

    // asynchronous reset in the middle of a message
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'hB0); send(8'h5E); send(8'h55);
    send(8'h90); send(8'h3D);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gate", gate, 4'b0000);
    check("arst_note", note, 28'h0);
    check("arst_detune", detune, 7'h00);
    check("arst_pitch", pitch, 14'h2000);
    check("arst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(8'h64);
    check("arst_partial_dropped", gate, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
